// File: rtl/dsp_mac_engine.sv
// rtl/dsp_mac_engine.sv - signed multiply-accumulate engine with grouped results and handshakes
// Optional feature macro: DSP_MAC_SAT_EN (saturating accumulate instead of wrapping)
module dsp_mac_engine #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int ACC_LEN   = 4,
  parameter int MREG      = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic signed [A_WIDTH-1:0]   A,
  input  logic signed [B_WIDTH-1:0]   B,
  input  logic                        SUB,
  input  logic                        CLR,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic signed [ACC_WIDTH-1:0] P,
  output logic                        OVF
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_LEN - 1);
  localparam int MSB = ACC_WIDTH - 1;

  logic [CNT_W-1:0]            cnt;
  logic                        accept;
  logic                        in_last;
  logic signed [ACC_WIDTH-1:0] prod;

  // Product/SUB/last-flag as seen by the accumulator (registered or direct)
  logic                        s_valid;
  logic                        s_sub;
  logic                        s_last;
  logic signed [ACC_WIDTH-1:0] s_prod;
  logic                        stall_last;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        ovf_step;
  logic                        ovf_sticky;

  // Operands widened first so the product is full precision and sign-extended
  assign prod = ACC_WIDTH'(A) * ACC_WIDTH'(B);

  // A last term sitting in the multiplier stage blocks intake so the result slot
  // is guaranteed free when it commits
  assign IN_READY = !RST && (!OUT_VALID || OUT_READY) && !CLR && !stall_last;
  assign accept   = IN_VALID && IN_READY;
  assign in_last  = (cnt == CNT_MAX);

  generate
    if (MREG != 0) begin : g_mreg
      // Multiplier pipeline register, advances every cycle, flushed by CLR
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          s_valid <= 1'b0;
          s_sub   <= 1'b0;
          s_last  <= 1'b0;
          s_prod  <= '0;
        end else begin
          s_valid <= accept && !CLR;
          s_sub   <= SUB;
          s_last  <= in_last;
          s_prod  <= prod;
        end
      end
      assign stall_last = s_valid && s_last;
    end else begin : g_comb
      assign s_valid    = accept;
      assign s_sub      = SUB;
      assign s_last     = in_last;
      assign s_prod     = prod;
      assign stall_last = 1'b0;
    end
  endgenerate

  // Term counter: position of the next accepted term within its group
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= in_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Add/subtract with signed overflow detection; acc is zero at group start,
  // so the first term naturally loads +product or -product
  always_comb begin
    sum      = s_sub ? (acc - s_prod) : (acc + s_prod);
    ovf_step = s_sub ? ((acc[MSB] != s_prod[MSB]) && (sum[MSB] != acc[MSB]))
                     : ((acc[MSB] == s_prod[MSB]) && (sum[MSB] != acc[MSB]));
    acc_next = sum;
`ifdef DSP_MAC_SAT_EN
    if (ovf_step) begin
      acc_next = acc[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
`endif
  end

  // Accumulator, sticky overflow and result register with output handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      P          <= '0;
      OVF        <= 1'b0;
      OUT_VALID  <= 1'b0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (CLR) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else if (s_valid) begin
        if (s_last) begin
          acc        <= '0;
          ovf_sticky <= 1'b0;
          P          <= acc_next;
          OVF        <= ovf_sticky || ovf_step;
          OUT_VALID  <= 1'b1;
        end else begin
          acc        <= acc_next;
          ovf_sticky <= ovf_sticky || ovf_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_engine.sv
// tb/tb_dsp_mac_engine.sv - directed self-checking bench for dsp_mac_engine
module tb_dsp_mac_engine;

  logic               CLK;
  logic               RST;
  logic               IN_VALID;
  logic               IN_READY;
  logic               IN_READY_36;
  logic signed [17:0] A;
  logic signed [17:0] B;
  logic               SUB;
  logic               CLR;
  logic               OUT_VALID;
  logic               OUT_VALID_36;
  logic               OUT_READY;
  logic signed [47:0] P;
  logic signed [35:0] P_36;
  logic               OVF;
  logic               OVF_36;

  int n_cmp;
  int n_err;

  dsp_mac_engine dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .SUB(SUB), .CLR(CLR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .P(P), .OVF(OVF)
  );

  dsp_mac_engine #(.ACC_WIDTH(36)) dut36 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY_36),
    .A(A), .B(B), .SUB(SUB), .CLR(CLR),
    .OUT_VALID(OUT_VALID_36), .OUT_READY(OUT_READY), .P(P_36), .OVF(OVF_36)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b, input logic s);
    int n;
    n = 0;
    A = 18'(a);
    B = 18'(b);
    SUB = s;
    IN_VALID = 1'b1;
    #1;
    while (!IN_READY && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("send_ready", IN_READY, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!OUT_VALID && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk(tag, OUT_VALID, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    IN_VALID = 1'b0;
    A = '0;
    B = '0;
    SUB = 1'b0;
    CLR = 1'b0;
    OUT_READY = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_p", P, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_in_ready", IN_READY, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Basic group and latency: 12 - 10 - 7 + 1 = -4
    send(3, 4, 1'b0);
    send(-2, 5, 1'b0);
    send(7, -1, 1'b0);
    send(1, 1, 1'b0);
    chk("lat_not_yet", OUT_VALID, 0);
    @(posedge CLK);
    #1;
    chk("lat_valid", OUT_VALID, 1);
    chk("basic_p", P, -4);
    chk("basic_ovf", OVF, 0);
    @(posedge CLK);
    #1;
    chk("one_cycle_valid", OUT_VALID, 0);

    // Per-term subtract: 6 - 6 - 6 - 6 = -12
    send(2, 3, 1'b0);
    send(2, 3, 1'b1);
    send(2, 3, 1'b1);
    send(2, 3, 1'b1);
    wait_out("sub_valid");
    chk("sub_p", P, -12);
    @(posedge CLK);
    #1;

    // Backpressure: result held, intake blocked
    OUT_READY = 1'b0;
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    wait_out("bp_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      chk("bp_hold_valid", OUT_VALID, 1);
      chk("bp_hold_p", P, 4);
      chk("bp_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp_drained", OUT_VALID, 0);
    chk("bp_in_ready_after", IN_READY, 1);

    // Overflow: four products of 2^34
    send(-131072, -131072, 1'b0);
    send(-131072, -131072, 1'b0);
    send(-131072, -131072, 1'b0);
    send(-131072, -131072, 1'b0);
    wait_out("ovf_valid");
    chk("ovf48_p", P, 64'sd68719476736);
    chk("ovf48_flag", OVF, 0);
    chk("ovf36_valid", OUT_VALID_36, 1);
`ifdef DSP_MAC_SAT_EN
    chk("ovf36_p", P_36, 64'sd34359738367);
`else
    chk("ovf36_p", P_36, 0);
`endif
    chk("ovf36_flag", OVF_36, 1);
    @(posedge CLK);
    #1;

    // Abort of a partial group via CLR
    send(5, 5, 1'b0);
    send(5, 5, 1'b0);
    CLR = 1'b1;
    #1;
    chk("clr_in_ready", IN_READY, 0);
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("clr_no_out", OUT_VALID, 0);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    chk("clr_no_early_out", OUT_VALID, 0);
    send(1, 1, 1'b0);
    wait_out("clr_valid");
    chk("clr_p", P, 4);
    @(posedge CLK);
    #1;

    // Asynchronous reset with a pending result
    OUT_READY = 1'b0;
    send(7, 7, 1'b0);
    send(7, 7, 1'b0);
    send(7, 7, 1'b0);
    send(7, 7, 1'b0);
    wait_out("rst_pend_valid");
    chk("rst_pend_p", P, 196);
    RST = 1'b1;
    #1;
    chk("arst_out_valid", OUT_VALID, 0);
    chk("arst_p", P, 0);
    chk("arst_in_ready", IN_READY, 0);
    #2;
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;

    // Asynchronous reset with three terms in flight, then a fresh group
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    send(1, 1, 1'b0);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    send(1, 2, 1'b0);
    send(1, 2, 1'b0);
    send(1, 2, 1'b0);
    chk("post_rst_no_early", OUT_VALID, 0);
    send(1, 2, 1'b0);
    wait_out("post_rst_valid");
    chk("post_rst_p", P, 8);
    chk("post_rst_ovf", OVF, 0);
    @(posedge CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
